// File: rtl/sprite_fetch_scheduler_if.sv
// Sprite memory fetch port: request/acknowledge handshake with slot and target line.
// The scheduler drives the master side, the sprite memory the slave side.
interface sprite_fetch_scheduler_if #(
  parameter int unsigned SLOT_W = 2
) ();
  logic              req;
  logic [SLOT_W-1:0] slot;
  logic [9:0]        line;
  logic              ack;

  modport master (
    output req,
    output slot,
    output line,
    input  ack
  );

  modport slave (
    input  req,
    input  slot,
    input  line,
    output ack
  );
endinterface

// File: rtl/sprite_fetch_scheduler.sv
// Per-scanline sprite prefetch: opens a fetch window at the front porch, walks enabled
// slots in order issuing one req/ack per slot, and flags lines that overrun active video.
module sprite_fetch_scheduler #(
  parameter int unsigned SLOT_W         = 2,
  parameter int unsigned H_FETCH_START  = 784,
  parameter int unsigned H_ACTIVE_START = 144,
  parameter int unsigned V_ACTIVE_START = 35,
  parameter int unsigned V_ACTIVE_END   = 514,
  parameter int unsigned V_MAX          = 524,
  localparam int unsigned NUM_SLOTS     = 2 ** SLOT_W
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [9:0]               pixel_x_i,
  input  logic [9:0]               pixel_y_i,
  input  logic [NUM_SLOTS-1:0]     slot_en_i,
  sprite_fetch_scheduler_if.master mem_if,
  output logic [NUM_SLOTS-1:0]     fetch_valid_o,
  output logic                     busy_o,
  output logic                     line_done_o,
  output logic                     line_overrun_o,
  output logic                     frame_tick_o
);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StReq
  } state_e;

  localparam logic [SLOT_W:0] IdxOne  = (SLOT_W + 1)'(1);
  localparam logic [SLOT_W:0] IdxLast = (SLOT_W + 1)'(NUM_SLOTS);

  state_e                 state_q, state_d;
  logic [SLOT_W:0]        idx_q, idx_d;
  logic [NUM_SLOTS-1:0]   pending_q, pending_d;
  logic                   deadline_q, deadline_d;
  logic                   req_q, req_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [9:0]             line_q, line_d;
  logic [NUM_SLOTS-1:0]   fetch_valid_q, fetch_valid_d;
  logic                   busy_q, busy_d;
  logic                   line_done_q, line_done_d;
  logic                   line_overrun_q, line_overrun_d;
  logic                   frame_tick_q, frame_tick_d;

  logic                   trigger;
  logic                   at_deadline;
  logic [9:0]             target;
  logic                   target_active;
  logic [SLOT_W-1:0]      idx_lo;

  assign trigger     = (pixel_x_i == 10'(H_FETCH_START));
  assign at_deadline = (pixel_x_i == 10'(H_ACTIVE_START));
  assign idx_lo      = idx_q[SLOT_W-1:0];

  // Wrap from the last frame line to line 0 explicitly rather than by counter overflow.
  assign target        = (pixel_y_i == 10'(V_MAX)) ? 10'd0 : pixel_y_i + 10'd1;
  assign target_active = (target >= 10'(V_ACTIVE_START)) && (target <= 10'(V_ACTIVE_END));

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    pending_d      = pending_q;
    deadline_d     = deadline_q;
    req_d          = req_q;
    slot_d         = slot_q;
    line_d         = line_q;
    fetch_valid_d  = fetch_valid_q;
    line_done_d    = 1'b0;
    line_overrun_d = 1'b0;
    frame_tick_d   = (pixel_x_i == 10'd0) && (pixel_y_i == 10'(V_ACTIVE_END + 1));

    if (busy_q && at_deadline) begin
      deadline_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (trigger) begin
          fetch_valid_d = '0;
          if (target_active) begin
            line_d    = target;
            pending_d = slot_en_i;
            idx_d     = '0;
            state_d   = StScan;
          end
        end
      end

      StScan: begin
        // A new window opening while still busy means this line can no longer finish in time.
        if (trigger) begin
          deadline_d = 1'b1;
        end
        if (deadline_q) begin
          state_d        = StIdle;
          line_overrun_d = 1'b1;
        end else if (idx_q == IdxLast) begin
          state_d     = StIdle;
          line_done_d = 1'b1;
        end else if (pending_q[idx_lo]) begin
          slot_d  = idx_lo;
          req_d   = 1'b1;
          state_d = StReq;
        end else begin
          idx_d = idx_q + IdxOne;
        end
      end

      StReq: begin
        if (trigger) begin
          deadline_d = 1'b1;
        end
        // An outstanding request always completes; the deadline is acted on in the next scan.
        if (mem_if.ack) begin
          req_d                 = 1'b0;
          fetch_valid_d[idx_lo] = 1'b1;
          idx_d                 = idx_q + IdxOne;
          state_d               = StScan;
        end
      end

      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase

    if (state_d == StIdle) begin
      deadline_d = 1'b0;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      pending_q      <= '0;
      deadline_q     <= 1'b0;
      req_q          <= 1'b0;
      slot_q         <= '0;
      line_q         <= '0;
      fetch_valid_q  <= '0;
      busy_q         <= 1'b0;
      line_done_q    <= 1'b0;
      line_overrun_q <= 1'b0;
      frame_tick_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      pending_q      <= pending_d;
      deadline_q     <= deadline_d;
      req_q          <= req_d;
      slot_q         <= slot_d;
      line_q         <= line_d;
      fetch_valid_q  <= fetch_valid_d;
      busy_q         <= busy_d;
      line_done_q    <= line_done_d;
      line_overrun_q <= line_overrun_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign mem_if.req     = req_q;
  assign mem_if.slot    = slot_q;
  assign mem_if.line    = line_q;
  assign fetch_valid_o  = fetch_valid_q;
  assign busy_o         = busy_q;
  assign line_done_o    = line_done_q;
  assign line_overrun_o = line_overrun_q;
  assign frame_tick_o   = frame_tick_q;

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Directed bench for sprite_fetch_scheduler: VGA position driver, sprite memory model with
// configurable ack latency, and a scoreboard of expected (slot, line) requests.
module tb_sprite_fetch_scheduler;

  localparam int unsigned SlotW = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [3:0] slot_en;
  logic [3:0] fetch_valid;
  logic       busy;
  logic       line_done;
  logic       line_overrun;
  logic       frame_tick;

  always #20 clk = ~clk;

  sprite_fetch_scheduler_if #(.SLOT_W(SlotW)) mem_if ();

  sprite_fetch_scheduler #(.SLOT_W(SlotW)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .pixel_x_i      (pixel_x),
    .pixel_y_i      (pixel_y),
    .slot_en_i      (slot_en),
    .mem_if         (mem_if.master),
    .fetch_valid_o  (fetch_valid),
    .busy_o         (busy),
    .line_done_o    (line_done),
    .line_overrun_o (line_overrun),
    .frame_tick_o   (frame_tick)
  );

  typedef struct packed {
    logic [1:0] slot;
    logic [9:0] line;
  } req_t;

  req_t sb[$];
  req_t cur;
  bit   have_cur = 1'b0;
  bit   in_flight = 1'b0;
  bit   busy_prev = 1'b0;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int trig_cyc = -1;
  int first_req_cyc = -1;
  int ack_lat = 0;
  int lat_cnt = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  int busy_cnt = 0;
  int req_cnt = 0;
  int tick_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit line_active(input logic [9:0] y);
    logic [9:0] t;
    t = (y == 10'd524) ? 10'd0 : y + 10'd1;
    return (t >= 10'd35) && (t <= 10'd514);
  endfunction

  // One clock: observe outputs for the inputs sampled at this edge, then drive the next ones.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    check("frame_tick", 32'(frame_tick),
          32'(!reset && (pixel_x == 10'd0) && (pixel_y == 10'd515)));
    if (frame_tick) tick_cnt++;
    if (!reset && (pixel_x == 10'd784)) begin
      trig_cyc = cyc;
      check("busy_at_trigger", 32'(busy), 32'(line_active(pixel_y)));
    end
    if (busy) busy_cnt++;
    if (line_done) begin
      done_cnt++;
      check("done_at_busy_fall", 32'({busy_prev, busy, line_overrun}), 32'h4);
    end
    if (line_overrun) begin
      ovr_cnt++;
      check("overrun_at_busy_fall", 32'({busy_prev, busy, line_done}), 32'h4);
    end
    busy_prev = busy;

    mem_if.ack = 1'b0;
    if (reset || !mem_if.req) begin
      in_flight = 1'b0;
    end else begin
      if (!in_flight) begin
        in_flight = 1'b1;
        lat_cnt   = ack_lat;
        req_cnt++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        if (sb.size() == 0) begin
          have_cur = 1'b0;
          check("unexpected_req", 32'(mem_if.req), 32'd0);
        end else begin
          cur      = sb.pop_front();
          have_cur = 1'b1;
        end
      end
      if (have_cur) begin
        check("mem_slot", 32'(mem_if.slot), 32'(cur.slot));
        check("mem_line", 32'(mem_if.line), 32'(cur.line));
      end
      if (lat_cnt == 0) mem_if.ack = 1'b1;
      lat_cnt--;
    end

    if (pixel_x == 10'd799) begin
      pixel_x = 10'd0;
      pixel_y = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
    end else begin
      pixel_x = pixel_x + 10'd1;
    end
  endtask

  task automatic expect_reqs(input logic [3:0] en, input logic [9:0] line);
    for (int s = 0; s < 4; s++) begin
      if (en[s]) sb.push_back('{slot: 2'(s), line: line});
    end
  endtask

  // Start a few pixels before the window, flip slot_en right after the trigger, then run n.
  task automatic run_line(input logic [9:0] y, input logic [3:0] en, input int lat, input int n);
    pixel_x       = 10'd781;
    pixel_y       = y;
    slot_en       = en;
    ack_lat       = lat;
    done_cnt      = 0;
    ovr_cnt       = 0;
    busy_cnt      = 0;
    req_cnt       = 0;
    trig_cyc      = -1;
    first_req_cyc = -1;
    for (int i = 0; i < 8 && trig_cyc < 0; i++) cycle();
    slot_en = ~en;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset      = 1'b1;
    pixel_x    = 10'd0;
    pixel_y    = 10'd0;
    slot_en    = 4'b0000;
    mem_if.ack = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("reset_outputs",
          32'({mem_if.req, mem_if.slot, mem_if.line, fetch_valid, busy, line_done,
               line_overrun, frame_tick}), 32'd0);
    reset = 1'b0;
    cycle();

    // All four slots, immediate ack; slot_en flips to 0000 after the trigger.
    expect_reqs(4'b1111, 10'd101);
    run_line(10'd100, 4'b1111, 0, 40);
    check("t1_done", 32'(done_cnt), 32'd1);
    check("t1_overrun", 32'(ovr_cnt), 32'd0);
    check("t1_fetch_valid", 32'(fetch_valid), 32'hF);
    check("t1_req_cnt", 32'(req_cnt), 32'd4);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    check("t1_first_req_latency", 32'(first_req_cyc - trig_cyc), 32'd1);
    check("t1_busy_len", 32'(busy_cnt), 32'd9);

    // Sparse enables: skipped slots cost one cycle each.
    expect_reqs(4'b0101, 10'd201);
    run_line(10'd200, 4'b0101, 0, 40);
    check("t2_done", 32'(done_cnt), 32'd1);
    check("t2_fetch_valid", 32'(fetch_valid), 32'h5);
    check("t2_req_cnt", 32'(req_cnt), 32'd2);
    check("t2_busy_len", 32'(busy_cnt), 32'd7);

    // Slow memory: slot 2 straddles the deadline, completes, then the line overruns.
    expect_reqs(4'b0111, 10'd301);
    run_line(10'd300, 4'b1111, 60, 220);
    check("t3_done", 32'(done_cnt), 32'd0);
    check("t3_overrun", 32'(ovr_cnt), 32'd1);
    check("t3_fetch_valid", 32'(fetch_valid), 32'h7);
    check("t3_req_cnt", 32'(req_cnt), 32'd3);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);
    check("t3_busy_len", 32'(busy_cnt), 32'd187);

    // Last frame line targets line 0, which is blanking.
    run_line(10'd524, 4'b1111, 0, 30);
    check("b524_fetch_valid", 32'(fetch_valid), 32'h0);
    check("b524_req_cnt", 32'(req_cnt), 32'd0);
    check("b524_pulses", 32'(done_cnt + ovr_cnt), 32'd0);

    // First active line.
    expect_reqs(4'b0011, 10'd35);
    run_line(10'd34, 4'b0011, 0, 30);
    check("b34_done", 32'(done_cnt), 32'd1);
    check("b34_fetch_valid", 32'(fetch_valid), 32'h3);
    check("b34_req_cnt", 32'(req_cnt), 32'd2);

    // Line after the last active line.
    run_line(10'd514, 4'b1111, 0, 30);
    check("b514_fetch_valid", 32'(fetch_valid), 32'h0);
    check("b514_req_cnt", 32'(req_cnt), 32'd0);
    check("b514_pulses", 32'(done_cnt + ovr_cnt), 32'd0);

    // Two passes over the start of vertical blanking: one tick each.
    for (int f = 0; f < 2; f++) begin
      pixel_x  = 10'd795;
      pixel_y  = 10'd514;
      tick_cnt = 0;
      for (int i = 0; i < 20; i++) cycle();
      check("frame_tick_count", 32'(tick_cnt), 32'd1);
    end

    // Reset while a request is outstanding.
    expect_reqs(4'b1110, 10'd401);
    pixel_x = 10'd781;
    pixel_y = 10'd400;
    slot_en = 4'b1110;
    ack_lat = 20;
    for (int i = 0; i < 20 && !mem_if.req; i++) cycle();
    check("req_before_reset", 32'(mem_if.req), 32'd1);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    check("reset_mid_req",
          32'({mem_if.req, mem_if.slot, mem_if.line, fetch_valid, busy, line_done,
               line_overrun, frame_tick}), 32'd0);
    reset = 1'b0;
    sb.delete();
    cycle();

    expect_reqs(4'b1111, 10'd402);
    run_line(10'd401, 4'b1111, 0, 40);
    check("post_reset_done", 32'(done_cnt), 32'd1);
    check("post_reset_fetch_valid", 32'(fetch_valid), 32'hF);
    check("post_reset_req_cnt", 32'(req_cnt), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_scheduler.md
# sprite_fetch_scheduler

Line-prefetch scheduler for the shared sprite memory port. It watches the pixel coordinates produced by the VGA sync unit and opens a fetch window at the start of every horizontal front porch. During that window it walks the enabled sprite slots in order and issues one req/ack transaction per slot for the next scanline. It reports which slots were fetched and flags lines whose fetches overran into active video. It also emits the once-per-frame game-logic tick at the start of vertical blanking.

## Interface
- SLOT_W, 2: slot index width; NUM_SLOTS = 2**SLOT_W.
- H_FETCH_START, 784: pixel_x value that opens the fetch window (first front-porch pixel).
- H_ACTIVE_START, 144: pixel_x value that is the fetch deadline (first active pixel).
- V_ACTIVE_START, 35: first active line.
- V_ACTIVE_END, 514: last active line.
- V_MAX, 524: last line of the frame.
- clk  in  1  25 MHz pixel clock.
- reset  in  1  synchronous, active-high.
- pixel_x  in  10  registered x position from the sync unit.
- pixel_y  in  10  registered y position from the sync unit.
- slot_en  in  NUM_SLOTS  per-slot enable; snapshotted at the window trigger.
- mem_ack  in  1  one-cycle acknowledge from the sprite memory.
- mem_req  out  1  request; held high until mem_ack is sampled.
- mem_slot  out  SLOT_W  slot being fetched; stable while mem_req is high.
- mem_line  out  10  target line; stable while mem_req is high.
- fetch_valid  out  NUM_SLOTS  slots fetched for the current target line.
- busy  out  1  high in SCAN or REQ.
- line_done  out  1  one-cycle pulse: all pending slots fetched before the deadline.
- line_overrun  out  1  one-cycle pulse: the deadline passed before all pending slots were fetched.
- frame_tick  out  1  one-cycle pulse at the start of vertical blanking.

## Operation
- All outputs are registered. Reset value of every output is 0. Internal state on reset: IDLE, pending = 0, deadline flag = 0.
- Trigger condition: pixel_x == H_FETCH_START.
  - target = (pixel_y == V_MAX) ? 0 : pixel_y + 1.
  - If target is outside [V_ACTIVE_START, V_ACTIVE_END]: fetch_valid <= 0, state stays IDLE, no pulse is emitted.
  - Otherwise: latch target into mem_line, pending <= slot_en, fetch_valid <= 0, idx <= 0, go to SCAN.
- States:
  - IDLE: wait for the trigger.
  - SCAN: takes 1 cycle per slot.
    - If the deadline flag is set: go to IDLE and pulse line_overrun.
    - Else if idx == NUM_SLOTS: go to IDLE and pulse line_done.
    - Else if pending[idx] is set: mem_slot <= idx, mem_req <= 1, go to REQ.
    - Else: idx <= idx + 1.
  - REQ: hold mem_req, mem_slot and mem_line. When mem_ack is sampled high: mem_req <= 0, fetch_valid[idx] <= 1, idx <= idx + 1, return to SCAN.
- Deadline flag:
  - Set when pixel_x == H_ACTIVE_START while busy.
  - Cleared on entry to IDLE.
  - An outstanding REQ is never aborted; it completes, then the next SCAN cycle exits with line_overrun. Remaining pending slots are skipped and keep fetch_valid = 0.
- Trigger while busy (window longer than a line): the trigger is ignored and the deadline flag is set.
- idx is SLOT_W+1 bits so that NUM_SLOTS is representable. mem_line is 10 bits, and wrap-around from V_MAX to 0 is handled explicitly, never by overflow.
- mem_ack while not in REQ is ignored.
- slot_en changes after the trigger have no effect until the next trigger.
- frame_tick pulses when pixel_x == 0 and pixel_y == V_ACTIVE_END + 1. It is independent of the FSM and may coincide with SCAN/REQ activity.
- Reset mid-REQ: mem_req drops at the reset edge, nothing is retried, and the memory side must tolerate the abandoned request.

## Timing
- Trigger sampled at edge t: busy = 1 and SCAN at t+1. mem_req = 1 at t+2 if slot_en[0] = 1.
- mem_ack sampled high at edge a: mem_req = 0 and fetch_valid bit set at a+1. Next SCAN at a+1, next mem_req earliest at a+2.
- Per-slot cost: 1 cycle per skipped slot. For a fetched slot: 2 cycles plus the ack latency.
- Fetch window = 160 cycles (16 front porch + 144 sync/back porch).
- line_done and line_overrun are mutually exclusive, each at most once per trigger, and are asserted in the cycle busy falls.
- frame_tick is asserted in the cycle after pixel_x == 0, pixel_y == 515 is sampled.

## Test plan
- slot_en = 1111, pixel_y = 100, ack 1 cycle after req -> four reqs with mem_slot 0,1,2,3 and mem_line 101; line_done once; fetch_valid = 1111; busy low well before pixel_x = 144.
- slot_en = 0101 -> reqs only for slots 0 and 2; skipped slots cost one cycle each; fetch_valid = 0101; line_done.
- ack latency 60 cycles, slot_en = 1111 -> slots 0 and 1 complete; slot 2 is outstanding at pixel_x = 144 and completes; line_overrun; fetch_valid = 0111; no req for slot 3.
- Boundaries:
  - Trigger at pixel_y = 524 -> target 0 (inactive): no req, fetch_valid = 0.
  - Trigger at pixel_y = 34 -> mem_line 35, fetches issued.
  - Trigger at pixel_y = 514 -> no fetch.
- Full frame run -> frame_tick exactly once per frame, one cycle after (0, 515) is sampled.
- reset asserted while mem_req = 1 -> all outputs 0 next cycle; the next trigger after reset release fetches normally.
